// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the multiply/divide unit and its requester.
// The master drives the start controls and operands; the slave returns results and status.
interface mult_div_unit_if;
  logic        MultCtrl;
  logic        DivCtrl;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        done;
  logic        DivZero;

  modport master (
    output MultCtrl, DivCtrl, A, B,
    input  HI, LO, busy, done, DivZero
  );

  modport slave (
    input  MultCtrl, DivCtrl, A, B,
    output HI, LO, busy, done, DivZero
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative 32x32 signed multiply (radix-2 Booth) and signed divide (restoring on magnitudes).
// Each operation takes 32 iterations; results land in HI/LO as the unit enters DONE.
module mult_div_unit (
  input logic            clk,
  input logic            reset,
  mult_div_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MULT_RUN = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [4:0]  count;
  logic [32:0] acc;    // Booth accumulator, or partial remainder when dividing
  logic [32:0] opnd;   // sign-extended multiplicand, or zero-extended divisor magnitude
  logic [31:0] qreg;   // multiplier bits, or dividend bits shifting into quotient
  logic        q_1;
  logic        neg_q, neg_r, dz_flag;
  logic [31:0] hi_r, lo_r;
  logic        last_iter;
  logic [31:0] a_mag, b_mag;

  assign last_iter = (count == 5'd31);
  assign a_mag     = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign b_mag     = bus.B[31] ? (32'd0 - bus.B) : bus.B;

  // One Booth step: add/subtract on {q0, q-1}, then arithmetic shift of {acc, qreg, q_1}.
  logic [32:0] booth_sum;
  logic [65:0] booth_shift;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    booth_sum = acc;
    case ({qreg[0], q_1})
      2'b01:   booth_sum = acc + opnd;
      2'b10:   booth_sum = acc - opnd;
      default: booth_sum = acc;
    endcase
    booth_shift = {booth_sum[32], booth_sum, qreg};
  end

  // One restoring-division step on magnitudes.
  logic [32:0] div_shift, div_diff;
  logic        div_ge;
  logic [31:0] quo_nxt, rem_nxt;
  assign div_shift = {acc[31:0], qreg[31]};
  assign div_diff  = div_shift - opnd;
  assign div_ge    = ~div_diff[32];
  assign quo_nxt   = {qreg[30:0], div_ge};
  assign rem_nxt   = div_ge ? div_diff[31:0] : div_shift[31:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.DivZero = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MultCtrl)     state_nxt = MULT_RUN;
        else if (bus.DivCtrl) state_nxt = (bus.B == 32'd0) ? DONE : DIV_RUN;
      end
      MULT_RUN, DIV_RUN: begin
        bus.busy = 1'b1;
        if (last_iter) state_nxt = DONE;
      end
      DONE: begin
        bus.done    = 1'b1;
        bus.DivZero = dz_flag;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      count   <= 5'd0;
      acc     <= 33'd0;
      opnd    <= 33'd0;
      qreg    <= 32'd0;
      q_1     <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz_flag <= 1'b0;
      hi_r    <= 32'd0;
      lo_r    <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          count   <= 5'd0;
          dz_flag <= 1'b0;
          if (bus.MultCtrl) begin
            acc  <= 33'd0;
            opnd <= {bus.A[31], bus.A};
            qreg <= bus.B;
            q_1  <= 1'b0;
          end else if (bus.DivCtrl) begin
            if (bus.B == 32'd0) begin
              dz_flag <= 1'b1;
            end else begin
              acc   <= 33'd0;
              opnd  <= {1'b0, b_mag};
              qreg  <= a_mag;
              neg_q <= bus.A[31] ^ bus.B[31];
              neg_r <= bus.A[31];
            end
          end
        end
        MULT_RUN: begin
          acc   <= booth_shift[65:33];
          qreg  <= booth_shift[32:1];
          q_1   <= booth_shift[0];
          count <= count + 5'd1;
          if (last_iter) begin
            hi_r <= booth_shift[64:33];
            lo_r <= booth_shift[32:1];
          end
        end
        DIV_RUN: begin
          acc   <= div_ge ? div_diff : div_shift;
          qreg  <= quo_nxt;
          count <= count + 5'd1;
          if (last_iter) begin
            hi_r <= neg_r ? (32'd0 - rem_nxt) : rem_nxt;
            lo_r <= neg_q ? (32'd0 - quo_nxt) : quo_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.HI = hi_r;
  assign bus.LO = lo_r;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: an arithmetic reference model compared every cycle,
// directed cases with literal expectations, and a randomized stimulus phase.
module tb_mult_div_unit;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  mult_div_unit_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining until IDLE plus the pending arithmetic result.
  int          m_left = 0;
  logic        m_dz   = 1'b0;
  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_res  = 64'd0;

  always @(posedge clk or posedge reset) begin
    longint la, lb, lq, lr;
    if (reset) begin
      m_left = 0;
      m_dz   = 1'b0;
      m_hi   = 32'd0;
      m_lo   = 32'd0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 1 && !m_dz) {m_hi, m_lo} = m_res;
    end else if (bus.MultCtrl) begin
      la     = longint'($signed(bus.A));
      lb     = longint'($signed(bus.B));
      m_res  = 64'(la * lb);
      m_left = 33;
      m_dz   = 1'b0;
    end else if (bus.DivCtrl) begin
      if (bus.B == 32'd0) begin
        m_left = 1;
        m_dz   = 1'b1;
      end else begin
        la     = longint'($signed(bus.A));
        lb     = longint'($signed(bus.B));
        lq     = la / lb;
        lr     = la % lb;
        m_res  = {lr[31:0], lq[31:0]};
        m_left = 33;
        m_dz   = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("cmp_busy",    64'(bus.busy),    64'(m_left > 1));
      check("cmp_done",    64'(bus.done),    64'(m_left == 1));
      check("cmp_divzero", 64'(bus.DivZero), 64'(m_left == 1 && m_dz));
      check("cmp_hi",      64'(bus.HI),      64'(m_hi));
      check("cmp_lo",      64'(bus.LO),      64'(m_lo));
    end
  end

  function automatic logic [31:0] pick_operand();
    case ($urandom % 6)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20)) - 32'd10;
      default: return $urandom;
    endcase
  endfunction

  // Presents a start for one cycle; cycle 1 is the first cycle after the sampling edge.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic mc, input logic dc,
                       input int pulse_at, output int cyc, output logic saw_dz);
    cyc    = -1;
    saw_dz = 1'b0;
    bus.A = a; bus.B = b; bus.MultCtrl = mc; bus.DivCtrl = dc;
    @(posedge clk); #1;
    bus.MultCtrl = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    for (int k = 1; k <= 60; k++) begin
      bus.DivCtrl = (k == pulse_at);
      if (bus.DivZero) saw_dz = 1'b1;
      if (bus.done) begin
        cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    bus.DivCtrl = 1'b0;
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      if (bus.done) n++;
    end
  endtask

  initial begin
    int   cyc, nd;
    logic dz;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    bus.A        = 32'd0;
    bus.B        = 32'd0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_hi",      64'(bus.HI),      64'd0);
    check("rst_lo",      64'(bus.LO),      64'd0);
    check("rst_busy",    64'(bus.busy),    64'd0);
    check("rst_done",    64'(bus.done),    64'd0);
    check("rst_divzero", 64'(bus.DivZero), 64'd0);
    reset = 1'b0;

    // 7 * -3, started on the first edge after reset release
    do_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0, 0, cyc, dz);
    check("mul1_latency", 64'(cyc), 64'd33);
    check("mul1_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("mul1_lo", 64'(bus.LO), 64'hFFFF_FFEB);

    @(posedge clk); #1;
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 0, cyc, dz);
    check("mul_min_hi", 64'(bus.HI), 64'h4000_0000);
    check("mul_min_lo", 64'(bus.LO), 64'h0000_0000);

    @(posedge clk); #1;
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1, 0, cyc, dz);
    check("div1_latency", 64'(cyc), 64'd33);
    check("div1_lo", 64'(bus.LO), 64'hFFFF_FFFD);
    check("div1_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("div1_divzero", 64'(dz), 64'd0);

    @(posedge clk); #1;
    do_op(32'h1234_5678, 32'd9, 1'b1, 1'b0, 0, cyc, dz);
    check("preload_lo", 64'(bus.LO), 64'hA3D7_0A38);
    @(posedge clk); #1;
    do_op(32'd5, 32'd0, 1'b0, 1'b1, 0, cyc, dz);
    check("dz_latency", 64'(cyc), 64'd1);
    check("dz_flag", 64'(dz), 64'd1);
    check("dz_hi_hold", 64'(bus.HI), 64'h0000_0000);
    check("dz_lo_hold", 64'(bus.LO), 64'hA3D7_0A38);
    @(posedge clk); #1;
    check("dz_done_drop", 64'(bus.done), 64'd0);
    check("dz_flag_drop", 64'(bus.DivZero), 64'd0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 0, cyc, dz);
    check("div_wrap_lo", 64'(bus.LO), 64'h8000_0000);
    check("div_wrap_hi", 64'(bus.HI), 64'h0000_0000);

    // Both starts together, then a stray divide request mid-operation
    @(posedge clk); #1;
    do_op(32'd6, 32'hFFFF_FFF9, 1'b1, 1'b1, 10, cyc, dz);
    check("both_latency", 64'(cyc), 64'd33);
    check("both_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("both_lo", 64'(bus.LO), 64'hFFFF_FFD6);
    count_done(45, nd);
    check("both_single_done", 64'(nd), 64'd0);

    // Reset in the middle of cycle 15 of a divide
    bus.A = 32'd100; bus.B = 32'd7; bus.DivCtrl = 1'b1;
    @(posedge clk); #1;
    bus.DivCtrl = 1'b0;
    repeat (14) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_hi",      64'(bus.HI),      64'd0);
    check("abort_lo",      64'(bus.LO),      64'd0);
    check("abort_busy",    64'(bus.busy),    64'd0);
    check("abort_done",    64'(bus.done),    64'd0);
    check("abort_divzero", 64'(bus.DivZero), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    count_done(40, nd);
    check("abort_no_done", 64'(nd), 64'd0);
    do_op(32'hFFFE_1DC0, 32'd789, 1'b1, 1'b0, 0, cyc, dz);
    check("post_abort_latency", 64'(cyc), 64'd33);
    check("post_abort_hi", 64'(bus.HI), 64'hFFFF_FFFF);
    check("post_abort_lo", 64'(bus.LO), 64'hFA31_B0C0);

    // Random starts every cycle, including requests while busy or in DONE
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      bus.MultCtrl = ($urandom % 10) == 0;
      bus.DivCtrl  = ($urandom % 8) == 0;
      bus.A        = pick_operand();
      bus.B        = pick_operand();
    end
    @(posedge clk); #1;
    bus.MultCtrl = 1'b0;
    bus.DivCtrl  = 1'b0;
    repeat (40) @(posedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
